// File: rtl/rom_streamer.sv
// Streams a block of consecutive ROM words out as a valid/ready stream, one word per cycle.
// Optional abort input is enabled by defining ROM_STREAM_ABORT_EN.
module rom_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
`ifdef ROM_STREAM_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   addr_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    valid_nxt, busy_nxt, done_nxt;
  logic [ADDR_WIDTH:0]     remaining, rem_nxt;
  logic                    abort_req;

`ifdef ROM_STREAM_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Address counter wraps naturally at the ROM depth.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return a + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_nxt = state;
    addr_nxt  = rom_addr;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    rem_nxt   = remaining;
    case (state)
      IDLE: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        if (start) begin
          if (length != '0) begin
            addr_nxt  = start_addr;
            rem_nxt   = length;
            busy_nxt  = 1'b1;
            state_nxt = FETCH;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      FETCH: begin
        if (abort_req) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else begin
          data_nxt  = rom_data;
          valid_nxt = 1'b1;
          addr_nxt  = next_addr(rom_addr);
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (abort_req) begin
          valid_nxt = 1'b0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end else if (out_ready) begin
          // remaining counts the word currently presented on out_data
          if (remaining > (ADDR_WIDTH+1)'(1)) begin
            data_nxt = rom_data;
            addr_nxt = next_addr(rom_addr);
            rem_nxt  = remaining - (ADDR_WIDTH+1)'(1);
          end else begin
            valid_nxt = 1'b0;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        valid_nxt = 1'b0;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rom_addr  <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
    end else begin
      state     <= state_nxt;
      rom_addr  <= addr_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      remaining <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_rom_streamer.sv
// Directed self-checking bench for rom_streamer with a combinational ROM model.
// Exercises the abort port only when ROM_STREAM_ABORT_EN is defined.
module tb_rom_streamer;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic [7:0] rom_addr, rom_data, out_data;
  logic       out_valid, busy, done;
`ifdef ROM_STREAM_ABORT_EN
  logic       abort;
`endif

  logic [7:0] rom [0:255];
  assign rom_data = rom[rom_addr];

  rom_streamer #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
    .rom_addr(rom_addr), .rom_data(rom_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef ROM_STREAM_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp4 [0:3];
  logic [7:0] got [0:511];
  int got_n, done_n, hold_err, busy_done_err, valid_seen;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Starts a transfer and records accepted words, done pulses and hold violations.
  task automatic run_xfer(input logic [7:0] a, input logic [8:0] len,
                          input logic [31:0] pat, input int maxc);
    logic       prev_v, prev_r;
    logic [7:0] prev_d;
    got_n = 0; done_n = 0; hold_err = 0; busy_done_err = 0; valid_seen = 0;
    start = 1'b1; start_addr = a; length = len;
    tick;
    start = 1'b0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = '0;
    for (int c = 0; c < maxc; c++) begin
      out_ready = pat[c % 32];
      if (out_valid && prev_v && !prev_r && out_data !== prev_d) hold_err++;
      if (out_valid && out_ready && got_n < 512) begin
        got[got_n] = out_data;
        got_n++;
      end
      prev_v = out_valid; prev_d = out_data; prev_r = out_ready;
      tick;
      if (done) begin
        done_n++;
        if (busy) busy_done_err++;
      end
      if (out_valid) valid_seen++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start_addr = 8'h33; length = 9'd3; out_ready = 1'b0;
`ifdef ROM_STREAM_ABORT_EN
    abort = 1'b0;
`endif
    tick; tick;
    rst = 1'b0;
    tests++;
    if (rom_addr !== 8'h00 || out_data !== 8'h00 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_state addr=%h data=%h valid=%b busy=%b done=%b expected all zero",
               rom_addr, out_data, out_valid, busy, done);
    end
  endtask

  task automatic test_basic_stream;
    start = 1'b1; start_addr = 8'h00; length = 9'd4; out_ready = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || out_valid !== 1'b0 || rom_addr !== 8'h00) begin
      fails++;
      $display("FAIL t1_fetch busy=%b valid=%b addr=%h expected busy=1 valid=0 addr=00", busy, out_valid, rom_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp4[k] || busy !== 1'b1 || done !== 1'b0) begin
        fails++;
        $display("FAIL t1_beat%0d valid=%b data=%h busy=%b done=%b expected valid=1 data=%h busy=1 done=0",
                 k, out_valid, out_data, busy, done, exp4[k]);
      end
    end
    tick;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || rom_addr !== 8'h04) begin
      fails++;
      $display("FAIL t1_done done=%b busy=%b valid=%b addr=%h expected done=1 busy=0 valid=0 addr=04",
               done, busy, out_valid, rom_addr);
    end
    tick;
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL t1_done_pulse done=%b expected 0", done);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    run_xfer(8'h00, 9'd4, 32'hFFFF_FF69, 16);
    tests++;
    if (got_n !== 4 || hold_err !== 0) begin
      fails++;
      $display("FAIL t2_count words=%0d hold_err=%0d expected words=4 hold_err=0", got_n, hold_err);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== exp4[k]) begin
        fails++;
        $display("FAIL t2_word%0d got=%h expected=%h", k, got[k], exp4[k]);
      end
    end
    tests++;
    if (done_n !== 1 || busy_done_err !== 0) begin
      fails++;
      $display("FAIL t2_done pulses=%0d busy_on_done=%0d expected 1 and 0", done_n, busy_done_err);
    end
  endtask

  task automatic test_wrap;
    logic [7:0] ew [0:3];
    ew[0] = 8'hE1; ew[1] = 8'hF3; ew[2] = 8'h09; ew[3] = 8'h15;
    run_xfer(8'hFE, 9'd4, 32'hFFFF_FFFF, 10);
    tests++;
    if (got_n !== 4 || done_n !== 1 || rom_addr !== 8'h02) begin
      fails++;
      $display("FAIL t3_wrap words=%0d done=%0d addr=%h expected words=4 done=1 addr=02", got_n, done_n, rom_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (got[k] !== ew[k]) begin
        fails++;
        $display("FAIL t3_word%0d got=%h expected=%h", k, got[k], ew[k]);
      end
    end
  endtask

  task automatic test_full_depth;
    run_xfer(8'h80, 9'd256, 32'hFFFF_FFFF, 262);
    tests++;
    if (got_n !== 256 || done_n !== 1 || rom_addr !== 8'h80) begin
      fails++;
      $display("FAIL full_count words=%0d done=%0d addr=%h expected words=256 done=1 addr=80", got_n, done_n, rom_addr);
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] ea;
      ea = 8'(8'h80 + i);
      tests++;
      if (got[i] !== rom[ea]) begin
        fails++;
        $display("FAIL full_word%0d got=%h expected=%h", i, got[i], rom[ea]);
      end
    end
  endtask

  task automatic test_zero_length;
    int vhigh = 0;
    start = 1'b1; start_addr = 8'h05; length = 9'd0; out_ready = 1'b1;
    tick;
    start = 1'b0;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL t4_len0 done=%b busy=%b valid=%b expected done=1 busy=0 valid=0", done, busy, out_valid);
    end
    for (int c = 0; c < 3; c++) begin
      tick;
      if (out_valid || busy || done) vhigh++;
    end
    tests++;
    if (vhigh !== 0) begin
      fails++;
      $display("FAIL t4_len0_quiet active_cycles=%0d expected 0", vhigh);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_start_while_busy;
    start = 1'b1; start_addr = 8'h00; length = 9'd4; out_ready = 1'b0;
    tick; tick;
    start = 1'b1; start_addr = 8'h10; length = 9'd2;
    tick; tick;
    tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h09 || rom_addr !== 8'h01 || busy !== 1'b1) begin
      fails++;
      $display("FAIL t4_busy_start valid=%b data=%h addr=%h busy=%b expected valid=1 data=09 addr=01 busy=1",
               out_valid, out_data, rom_addr, busy);
    end
    start = 1'b0; out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick;
      tests++;
      if (out_data !== exp4[k] || out_valid !== 1'b1) begin
        fails++;
        $display("FAIL t4_cont%0d data=%h valid=%b expected data=%h valid=1", k, out_data, out_valid, exp4[k]);
      end
    end
    tick;
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL t4_cont_done done=%b busy=%b expected done=1 busy=0", done, busy);
    end
    out_ready = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    start = 1'b1; start_addr = 8'h00; length = 9'd4; out_ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL t5_rst valid=%b busy=%b done=%b expected 0 0 0", out_valid, busy, done);
    end
    tick;
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL t5_rst_quiet done=%b valid=%b expected 0 0", done, out_valid);
    end
    run_xfer(8'h02, 9'd2, 32'hFFFF_FFFF, 6);
    tests++;
    if (got_n !== 2 || got[0] !== 8'h1C || got[1] !== 8'h2A || done_n !== 1) begin
      fails++;
      $display("FAIL t5_restart words=%0d w0=%h w1=%h done=%0d expected 2 1c 2a 1", got_n, got[0], got[1], done_n);
    end
  endtask

`ifdef ROM_STREAM_ABORT_EN
  task automatic test_abort;
    start = 1'b1; start_addr = 8'h00; length = 9'd4; out_ready = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    abort = 1'b1;
    tick;
    abort = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== 8'h15 || rom_addr !== 8'h02) begin
      fails++;
      $display("FAIL t6_abort valid=%b busy=%b done=%b data=%h addr=%h expected 0 0 0 15 02",
               out_valid, busy, done, out_data, rom_addr);
    end
    tick;
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL t6_abort_quiet done=%b valid=%b expected 0 0", done, out_valid);
    end
    out_ready = 1'b0;
  endtask
`else
  task automatic test_abort;
    run_xfer(8'h00, 9'd4, 32'hFFFF_FFFF, 8);
    tests++;
    if (got_n !== 4 || done_n !== 1 || got[3] !== 8'h2A) begin
      fails++;
      $display("FAIL t6_noabort words=%0d done=%0d last=%h expected 4 1 2a", got_n, done_n, got[3]);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
    rom[0] = 8'h09; rom[1] = 8'h15; rom[2] = 8'h1C; rom[3] = 8'h2A;
    rom[254] = 8'hE1; rom[255] = 8'hF3;
    exp4[0] = 8'h09; exp4[1] = 8'h15; exp4[2] = 8'h1C; exp4[3] = 8'h2A;

    test_reset;
    test_basic_stream;
    test_backpressure;
    test_wrap;
    test_full_depth;
    test_zero_length;
    test_start_while_busy;
    test_reset_mid;
    test_abort;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
